// File: rtl/pellet_draw.sv
// Pellet pool: accepts spawns into a 16-slot store, moves pellets up once per frame,
// and answers the per-pixel "is this pixel on a pellet" query with one cycle of latency.
module pellet_draw #(
    parameter int NUM_SLOTS   = 16,
    parameter int PELLET_SIZE = 4,
    parameter int SPEED       = 6,
    parameter int Y_MAX       = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       spawn_valid,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    output logic       spawn_ready,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_pellet,
    output logic [4:0] active_count,
    output logic       busy
);

    localparam int IDX_W = 4;
    localparam logic [9:0]  SPEED_C = 10'(SPEED);
    localparam logic [9:0]  Y_MAX_C = 10'(Y_MAX);
    localparam logic [10:0] PSIZE_C = 11'(PELLET_SIZE);
    localparam logic [4:0]  FULL_C  = 5'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MOVE = 1'b1
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     sweep_idx_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic [9:0]           slot_x_q [NUM_SLOTS];
    logic [9:0]           slot_y_q [NUM_SLOTS];
    logic [4:0]           active_count_q;
    logic                 is_pellet_q;

    logic [IDX_W-1:0]     free_idx_s;
    logic                 accept_s;
    logic                 hit_s;

    assign spawn_ready  = (state_q == S_IDLE) && (active_count_q < FULL_C);
    assign accept_s     = spawn_valid && spawn_ready && (spawn_y < Y_MAX_C);
    assign busy         = (state_q == S_MOVE);
    assign active_count = active_count_q;
    assign is_pellet    = is_pellet_q;

    // Lowest-index free slot; scanning downward lets the lowest free index win.
    always_comb begin
        free_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            free_idx_s = slot_valid_q[i] ? free_idx_s : IDX_W'(i);
        end
    end

    // Pixel hit test over all live slots; 11-bit sums keep pellets near x=1023 from wrapping.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_s = hit_s | (slot_valid_q[i]
                && ({1'b0, DrawX} >= {1'b0, slot_x_q[i]})
                && ({1'b0, DrawX} <  ({1'b0, slot_x_q[i]} + PSIZE_C))
                && ({1'b0, DrawY} >= {1'b0, slot_y_q[i]})
                && ({1'b0, DrawY} <  ({1'b0, slot_y_q[i]} + PSIZE_C)));
        end
    end

    // Pool state machine: spawns while idle, one slot moved or retired per sweep cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            sweep_idx_q    <= {IDX_W{1'b0}};
            slot_valid_q   <= {NUM_SLOTS{1'b0}};
            active_count_q <= 5'd0;
            is_pellet_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x_q[i] <= 10'd0;
                slot_y_q[i] <= 10'd0;
            end
        end else begin
            is_pellet_q <= hit_s;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        slot_valid_q[free_idx_s] <= 1'b1;
                        slot_x_q[free_idx_s]     <= spawn_x;
                        slot_y_q[free_idx_s]     <= spawn_y;
                        active_count_q           <= active_count_q + 5'd1;
                    end
                    if (frame_tick) begin
                        state_q     <= S_MOVE;
                        sweep_idx_q <= {IDX_W{1'b0}};
                    end
                end
                S_MOVE: begin
                    if (slot_valid_q[sweep_idx_q]) begin
                        if (slot_y_q[sweep_idx_q] >= SPEED_C) begin
                            slot_y_q[sweep_idx_q] <= slot_y_q[sweep_idx_q] - SPEED_C;
                        end else begin
                            slot_valid_q[sweep_idx_q] <= 1'b0;
                            active_count_q            <= active_count_q - 5'd1;
                        end
                    end
                    if (sweep_idx_q == LAST_IDX_C) begin
                        state_q <= S_IDLE;
                    end
                    sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                end
                default: begin
                    state_q     <= S_IDLE;
                    sweep_idx_q <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/pellet_draw.md
Name: pellet_draw

Overview:
Consumer end of the pellet path. Accepts pellet spawns from the shooter logic and holds them in a 16-slot pool. Once per frame it sweeps the pool to move every pellet upward and retire pellets that leave the screen. Per pixel, it answers whether the current VGA pixel lies on any live pellet, for the colour mapper.

Parameters:
NUM_SLOTS, 16, number of pellet slots (power of two, fixed 4-bit index)
PELLET_SIZE, 4, pellet edge length in pixels (square sprite)
SPEED, 6, pixels a pellet moves up per frame
Y_MAX, 480, screen height; spawns with y >= Y_MAX are rejected

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
spawn_valid  in  1  spawn request
spawn_x  in  10  spawn x (top-left corner of pellet)
spawn_y  in  10  spawn y (top-left corner of pellet)
spawn_ready  out  1  pool can accept a spawn this cycle
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
is_pellet  out  1  registered: previous-cycle pixel lies on a live pellet
active_count  out  5  number of live slots, 0..16
busy  out  1  movement sweep in progress

Behaviour:
- Reset (synchronous, active-high, Clk): all slot valid bits 0, slot x/y 0, state IDLE, sweep index 0, is_pellet 0, active_count 0, busy 0. Reset mid-sweep aborts the sweep immediately.
- Slot storage: valid bit, x[9:0] and y[9:0] per slot.
- spawn_ready = (state == IDLE) && (active_count < 16). It is combinational from registered state.
- Spawn handshake: a spawn is accepted on a Clk edge where spawn_valid && spawn_ready && spawn_y < Y_MAX.
  - An accepted spawn is written to the lowest-index invalid slot and sets that slot's valid bit.
  - active_count increments on that edge.
  - A spawn with spawn_y >= Y_MAX while ready is consumed and dropped. No slot changes and no count change.
  - A spawn_valid held high spawns once per cycle. The source deasserts after one cycle for a single pellet.
- FSM states: IDLE, MOVE.
  - IDLE -> MOVE on frame_tick. The sweep index is cleared to 0.
  - In MOVE, one slot is processed per cycle at the sweep index:
    - If the slot is valid and y >= SPEED: y <= y - SPEED.
    - If the slot is valid and y < SPEED: valid <= 0 and active_count decrements.
    - If the slot is invalid: no change.
  - MOVE -> IDLE after processing index NUM_SLOTS-1. A full sweep takes exactly 16 cycles.
  - busy = 1 exactly during MOVE.
- frame_tick during MOVE is ignored. It is neither queued nor restarting.
- Simultaneous spawn accept and frame_tick in IDLE: the spawn is written on that edge and MOVE begins on the next cycle. The new pellet is included in that sweep and moves by SPEED in the same frame.
- Spawns are never accepted during MOVE, because spawn_ready = 0.
- Hit test: a pixel hits when any valid slot i satisfies:
  - x_i <= DrawX < x_i + PELLET_SIZE, and
  - y_i <= DrawY < y_i + PELLET_SIZE.
  - Sums are computed in 11 bits so that a pellet at x = 1020..1023 does not wrap.
- is_pellet is registered: it reflects DrawX/DrawY and slot state sampled at the previous edge, giving 1-cycle latency.
- The hit test runs in every state, including MOVE, using current slot values. Tearing during blank is acceptable.
- No horizontal clipping. Pellets at x >= 640 are simply never hit by visible pixels.

Test Plan:
1. Reset, then spawn (100,200); query DrawX=101, DrawY=202 -> is_pellet=1 one cycle later, active_count=1. Query DrawX=104, DrawY=200 -> is_pellet=0.
2. Spawn (100,200), then pulse frame_tick -> busy high for exactly 16 cycles. Afterwards slot y=194; pixel (100,194) hits and pixel (100,199) misses.
3. Spawn with y=5, then frame_tick -> after the sweep active_count=0 and pixel (x,5) misses. Spawn with y=6, then frame_tick -> y=0 and the pellet stays live.
4. Hold spawn_valid for 17 cycles -> 16 pellets accepted, spawn_ready falls after the 16th, active_count=16. Retire slot 3 via y<SPEED -> the next spawn lands in slot 3.
5. Assert spawn_valid and frame_tick in the same IDLE cycle with y=300 -> pellet accepted; after the sweep y=294. A spawn attempted during MOVE is not accepted (spawn_ready=0). A second frame_tick mid-sweep -> sweep still ends after 16 cycles total.
6. Assert Reset at sweep cycle 7 with 5 live pellets -> next cycle busy=0, active_count=0, is_pellet=0. Spawn at y=480 -> dropped, active_count stays 0.
